mem_port_scheduler: RTL and testbench

Shares one memory-side request port among NUM_PORTS requesters, one burst at a time. Requesters are picked round-robin. The granted request is latched, and its address is sequenced beat-by-beat onto the memory port under a valid/ready handshake. The block sits between the per-core miss/writeback queues and the single external memory interface.

---
 rtl/mem_sched_pkg.sv | 8 +
 rtl/rr_select.sv | 16 +
 rtl/mem_port_scheduler.sv | 133 +++++++++++++
 tb/tb_mem_port_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared FSM state type, watchdog limit and width helper for mem_port_scheduler
package mem_sched_pkg;
   typedef enum logic {IDLE, BURST} state_t;
   localparam int MEM_SCHED_WDOG_CYCLES = 256;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin pick, first request at or after the one-hot pointer
module rr_select
   import mem_sched_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] req_i,
   input  logic [N-1:0] ptr_i,
   output logic [N-1:0] grant_o
);
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] gnt;
   assign dbl     = {req_i, req_i};
   assign gnt     = dbl & ~(dbl - {{N{1'b0}}, ptr_i});
   assign grant_o = gnt[N-1:0] | gnt[2*N-1:N];
endmodule

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: round-robin burst sequencer onto one memory port; optional watchdog via MEM_SCHED_WATCHDOG_EN
module mem_port_scheduler
   import mem_sched_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int BEAT_BYTES = 4,
   parameter int LEN_WIDTH  = 3
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            req_valid,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_PORTS-1:0]            req_write,
   input  logic [NUM_PORTS*LEN_WIDTH-1:0]  req_len,
   output logic [NUM_PORTS-1:0]            req_ack_oh,
   output logic [NUM_PORTS-1:0]            done_oh,
   output logic                            mem_valid,
   input  logic                            mem_ready,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic                            mem_write,
   output logic [idx_w(NUM_PORTS)-1:0]     mem_port,
   output logic                            mem_last,
   output logic                            busy,
   output logic                            timeout_err
);
   localparam int PW = idx_w(NUM_PORTS);
   localparam int SH = $clog2(BEAT_BYTES);
   state_t                state_q, state_d;
   logic [NUM_PORTS-1:0]  ptr_q, ptr_d, grant, ack_q, ack_d, done_q, done_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d, beat_q, beat_d;
   logic [PW-1:0]         port_q, port_d, gidx;
   logic                  last, expire;

   rr_select #(.N(NUM_PORTS)) u_rr (.req_i(req_valid), .ptr_i(ptr_q), .grant_o(grant));

   assign last        = beat_q == len_q;
   assign busy        = state_q == BURST;
   assign mem_valid   = busy;
   assign mem_last    = busy && last;
   assign mem_addr    = addr_q + (ADDR_WIDTH'(beat_q) << SH);
   assign mem_write   = write_q;
   assign mem_port    = port_q;
   assign req_ack_oh  = ack_q;
   assign done_oh     = done_q;

`ifdef MEM_SCHED_WATCHDOG_EN
   localparam int WW = $clog2(MEM_SCHED_WDOG_CYCLES);
   logic [WW-1:0] wdog_q, wdog_d;
   logic          tmo_q;
   assign expire      = busy && !mem_ready && wdog_q == WW'(MEM_SCHED_WDOG_CYCLES - 1);
   assign timeout_err = tmo_q;
   // stall counter: zero on burst entry and every accepted beat
   always_comb wdog_d = (!busy || mem_ready || expire) ? '0 : wdog_q + 1'b1;
   // watchdog registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdog_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         tmo_q  <= expire;
      end
   end
`else
   assign expire      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // one-hot grant to port index
   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_PORTS; i++) if (grant[i]) gidx = PW'(i);
   end

   // FSM next state: arbitrate in IDLE, step beats in BURST, finish on last beat or watchdog
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      write_d = write_q;
      len_d   = len_q;
      port_d  = port_q;
      beat_d  = beat_q;
      ack_d   = '0;
      done_d  = '0;
      if (state_q == IDLE) begin
         if (|grant) begin
            state_d = BURST;
            ptr_d   = {grant[NUM_PORTS-2:0], grant[NUM_PORTS-1]};
            addr_d  = req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
            write_d = req_write[gidx];
            len_d   = req_len[gidx*LEN_WIDTH +: LEN_WIDTH];
            port_d  = gidx;
            beat_d  = '0;
            ack_d   = grant;
         end
      end else if (expire || (mem_ready && last)) begin
         state_d = IDLE;
         beat_d  = '0;
         done_d  = NUM_PORTS'(1) << port_q;
      end else if (mem_ready) begin
         beat_d = beat_q + 1'b1;
      end
   end

   // state, latched request and pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= NUM_PORTS'(1);
         addr_q  <= '0;
         write_q <= 1'b0;
         len_q   <= '0;
         port_q  <= '0;
         beat_q  <= '0;
         ack_q   <= '0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         len_q   <= len_d;
         port_q  <= port_d;
         beat_q  <= beat_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb_mem_port_scheduler: directed scoreboard bench for mem_port_scheduler
module tb_mem_port_scheduler;
   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req_valid;
   logic [127:0] req_addr;
   logic [3:0]   req_write;
   logic [11:0]  req_len;
   logic [3:0]   req_ack_oh, done_oh;
   logic         mem_valid, mem_ready, mem_write, mem_last, busy, timeout_err;
   logic [31:0]  mem_addr;
   logic [1:0]   mem_port;

   typedef struct {
      logic [31:0] a;
      logic        w;
      logic [1:0]  p;
      logic        l;
   } beat_t;
   beat_t exp_q[$];
   int n_chk = 0;
   int n_fail = 0;

   mem_port_scheduler dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
      .req_write(req_write), .req_len(req_len), .req_ack_oh(req_ack_oh),
      .done_oh(done_oh), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_write(mem_write), .mem_port(mem_port),
      .mem_last(mem_last), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int p, input logic [31:0] a, input int len, input logic w);
      req_addr[p*32 +: 32] = a;
      req_len[p*3 +: 3]    = 3'(len);
      req_write[p]         = w;
   endtask

   task automatic push_burst(input int p, input logic [31:0] a, input int len, input logic w);
      beat_t e;
      for (int b = 0; b <= len; b++) begin
         e.a = a + 32'(b * 4);
         e.w = w;
         e.p = 2'(p);
         e.l = (b == len);
         exp_q.push_back(e);
      end
   endtask

   task automatic cyc();
      beat_t e;
      if (mem_valid && mem_ready) begin
         n_chk++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL beat_unexpected: observed addr %0h expected no beat", mem_addr);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat_addr", mem_addr, e.a);
            chk("beat_write", mem_write, e.w);
            chk("beat_port", mem_port, e.p);
            chk("beat_last", mem_last, e.l);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, mem_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ack"}, req_ack_oh, 0);
      chk({tag, "_done"}, done_oh, 0);
      chk({tag, "_last"}, mem_last, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_port"}, mem_port, 0);
      chk({tag, "_write"}, mem_write, 0);
      chk({tag, "_tmo"}, timeout_err, 0);
   endtask

   initial begin
      logic tmo_seen;
      reset = 1'b1; req_valid = '0; req_addr = '0; req_write = '0; req_len = '0; mem_ready = 1'b0;
      @(negedge clk); @(negedge clk);
      chk_idle("reset");
      reset = 1'b0;
      cyc();
      chk("post_reset_busy", busy, 0);

      // round robin: all ports, len 0
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 32'h1000 + 32'(i * 16), 0, 1'(i));
      for (int k = 0; k < 5; k++) push_burst(k % 4, 32'h1000 + 32'((k % 4) * 16), 0, 1'(k % 2));
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("rr_ack", req_ack_oh, 4'b1 << (k % 4));
         chk("rr_valid", mem_valid, 1);
         cyc();
         chk("rr_done", done_oh, 4'b1 << (k % 4));
         chk("rr_bubble", mem_valid, 0);
      end
      req_valid = '0;
      cyc();
      chk("rr_idle", busy, 0);

      // single request port 2, addr 0x100, len 3
      set_req(2, 32'h100, 3, 1'b1);
      push_burst(2, 32'h100, 3, 1'b1);
      req_valid = 4'b0100;
      cyc();
      chk("t1_ack", req_ack_oh, 4'b0100);
      chk("t1_valid", mem_valid, 1);
      req_valid = '0;
      for (int b = 0; b < 4; b++) cyc();
      chk("t1_done", done_oh, 4'b0100);
      chk("t1_idle", busy, 0);

      // backpressure: port 1, addr 0x2000, len 3, stall on beat 1
      set_req(1, 32'h2000, 3, 1'b0);
      push_burst(1, 32'h2000, 3, 1'b0);
      req_valid = 4'b0010;
      cyc();
      chk("bp_ack", req_ack_oh, 4'b0010);
      req_valid = '0;
      cyc();
      mem_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         chk("bp_valid", mem_valid, 1);
         chk("bp_addr", mem_addr, 32'h2004);
         chk("bp_write", mem_write, 0);
         cyc();
      end
      mem_ready = 1'b1;
      for (int b = 0; b < 3; b++) cyc();
      chk("bp_done", done_oh, 4'b0010);

      // address wrap: port 3, 0xFFFFFFFC, len 1
      set_req(3, 32'hFFFF_FFFC, 1, 1'b1);
      push_burst(3, 32'hFFFF_FFFC, 1, 1'b1);
      req_valid = 4'b1000;
      cyc();
      chk("wrap_ack", req_ack_oh, 4'b1000);
      req_valid = '0;
      cyc();
      cyc();
      chk("wrap_done", done_oh, 4'b1000);

      // reset during beat 2 of a 4-beat burst on port 2
      set_req(2, 32'h300, 3, 1'b1);
      push_burst(2, 32'h300, 3, 1'b1);
      req_valid = 4'b0100;
      cyc();
      chk("rst_ack", req_ack_oh, 4'b0100);
      req_valid = '0;
      cyc();
      cyc();
      chk("rst_beat2_addr", mem_addr, 32'h308);
      reset = 1'b1;
      #1;
      chk_idle("midrst");
      exp_q.delete();
      cyc();
      chk_idle("midrst_hold");
      reset = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 32'h4000 + 32'(i * 16), 0, 1'b0);
      push_burst(0, 32'h4000, 0, 1'b0);
      req_valid = 4'b1111;
      cyc();
      chk("rst_nodone", done_oh, 0);
      chk("rst_first_ack", req_ack_oh, 4'b0001);
      req_valid = '0;
      cyc();
      chk("rst_first_done", done_oh, 4'b0001);

      // long stall on port 1
      set_req(1, 32'h5000, 0, 1'b1);
      push_burst(1, 32'h5000, 0, 1'b1);
      mem_ready = 1'b0;
      req_valid = 4'b0010;
      cyc();
      chk("stall_ack", req_ack_oh, 4'b0010);
      req_valid = '0;
`ifdef MEM_SCHED_WATCHDOG_EN
      for (int s = 0; s < 256; s++) cyc();
      chk("wdog_tmo", timeout_err, 1);
      chk("wdog_done", done_oh, 4'b0010);
      cyc();
      chk("wdog_idle", busy, 0);
      chk("wdog_tmo_pulse", timeout_err, 0);
      exp_q.delete();
      mem_ready = 1'b1;
`else
      tmo_seen = 1'b0;
      for (int s = 0; s < 1000; s++) begin
         tmo_seen = tmo_seen | timeout_err;
         cyc();
      end
      chk("stall_no_tmo", tmo_seen, 0);
      chk("stall_valid", mem_valid, 1);
      chk("stall_addr", mem_addr, 32'h5000);
      mem_ready = 1'b1;
      cyc();
      chk("stall_done", done_oh, 4'b0010);
`endif
      cyc();
      chk("sb_drain", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
